// File: rtl/cpu_mem_pkg.sv
// Shared constants and types for the I/D-cache external memory port.
// Latency: n/a (declarations only). Backpressure: n/a.
// Contents: bus widths, burst geometry, arbiter state encoding, line-base helper.
package cpu_mem_pkg;

  localparam int ADDR_W     = 32;
  localparam int DATA_W     = 32;
  localparam int LINE_WORDS = 4;
  localparam int BEAT_W     = $clog2(LINE_WORDS);

  // Byte offset inside one cache line: beat index plus the 2-bit byte-in-word.
  localparam int OFF_W = BEAT_W + 2;

  // Clears the in-line offset bits, leaving the line base address.
  localparam logic [ADDR_W-1:0] LINE_MASK = {ADDR_W{1'b1}} << OFF_W;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    I_RD = 2'd1,
    D_RD = 2'd2,
    D_WR = 2'd3
  } state_t;

  function automatic logic [ADDR_W-1:0] line_base(input logic [ADDR_W-1:0] addr);
    return addr & LINE_MASK;
  endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bundle of every signal between the arbiter, the two cache controllers and memory.
// Latency: n/a (wires only). Backpressure: requests are held until *_done; memory stalls via mem_ack.
// Modports: master = the arbiter itself, slave = its environment (I-cache, D-cache, memory wrapper).
interface mem_port_arbiter_if;
  import cpu_mem_pkg::*;

  // Instruction-cache refill side
  logic              i_req;
  logic [ADDR_W-1:0] i_addr;
  logic              i_rvalid;
  logic [DATA_W-1:0] i_rdata;
  logic              i_done;

  // Data-cache refill / write-back side
  logic              d_req;
  logic              d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic [BEAT_W-1:0] d_beat;
  logic              d_rvalid;
  logic [DATA_W-1:0] d_rdata;
  logic              d_done;

  // External memory port, one word per beat
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ack;

  modport master (
    input  i_req, i_addr,
    output i_rvalid, i_rdata, i_done,
    input  d_req, d_we, d_addr, d_wdata,
    output d_beat, d_rvalid, d_rdata, d_done,
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_rdata, mem_ack
  );

  modport slave (
    output i_req, i_addr,
    input  i_rvalid, i_rdata, i_done,
    output d_req, d_we, d_addr, d_wdata,
    input  d_beat, d_rvalid, d_rdata, d_done,
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_rdata, mem_ack
  );

endinterface

// File: rtl/rr_arb2.sv
// Two-input round-robin picker between the I side and the D side.
// Latency: pick is combinational; the last-grant pointer updates on the clock edge where take=1.
// Backpressure: none; the caller only asserts take when it actually starts a burst.
// Ports: clk, resetn (sync, active-low); i_req, d_req requests; take = grant accepted this cycle;
//        pick_d = D wins (only meaningful when any=1); any = at least one request present.
module rr_arb2 (
  input  logic clk,
  input  logic resetn,
  input  logic i_req,
  input  logic d_req,
  input  logic take,
  output logic pick_d,
  output logic any
);

  // 1 = D side was granted last. Reset to "I last" so D wins the first tie.
  logic last_d;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      last_d <= 1'b0;
    end else if (take) begin
      last_d <= pick_d;
    end
  end

  assign any = i_req | d_req;

  // D wins if it is alone, or if both ask and I had the previous grant.
  assign pick_d = d_req & (~i_req | ~last_d);

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one external memory port between I-cache line refills and D-cache line refill/write-back.
// Latency: request seen in IDLE at edge N gives mem_req from cycle N+1; a burst is LINE_WORDS acked
//          beats, followed by exactly one IDLE cycle. Backpressure: memory stalls a beat by holding
//          mem_ack low (address/we/wdata held); a waiting requester simply keeps *_req high.
// Ports: clk, resetn (sync, active-low) plus the bus interface (master modport).
module mem_port_arbiter
  import cpu_mem_pkg::*;
(
  input  logic                 clk,
  input  logic                 resetn,
  mem_port_arbiter_if.master   bus
);

  state_t            state;
  state_t            state_nxt;
  logic [BEAT_W-1:0] beat;
  logic [BEAT_W-1:0] beat_nxt;
  logic [ADDR_W-1:0] base;
  logic [ADDR_W-1:0] base_nxt;

  logic pick_d;
  logic any;
  logic take;
  logic busy;
  logic is_d;
  logic is_rd_i;
  logic is_rd_d;
  logic beat_done;
  logic last;

  // ---------------------------------------------------------------------------
  // Arbitration: only consulted in IDLE, so the pointer moves once per burst.
  // ---------------------------------------------------------------------------
  assign take = (state == IDLE) & any;

  rr_arb2 u_rr_arb2 (
    .clk    (clk),
    .resetn (resetn),
    .i_req  (bus.i_req),
    .d_req  (bus.d_req),
    .take   (take),
    .pick_d (pick_d),
    .any    (any)
  );

  assign busy    = (state != IDLE);
  assign is_d    = (state == D_RD) | (state == D_WR);
  assign is_rd_i = (state == I_RD);
  assign is_rd_d = (state == D_RD);

  // An ack while idle is not a beat; gating with busy keeps it from touching anything.
  assign beat_done = busy & bus.mem_ack;
  assign last      = beat_done & (beat == BEAT_W'(LINE_WORDS - 1));

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state <= IDLE;
      beat  <= '0;
      base  <= '0;
    end else begin
      state <= state_nxt;
      beat  <= beat_nxt;
      base  <= base_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_nxt = state;
    beat_nxt  = beat;
    base_nxt  = base;

    case (state)
      IDLE: begin
        if (any) begin
          // Line base and direction are captured here and held for the whole burst,
          // so the requester's address bus may change without affecting it.
          base_nxt = pick_d ? line_base(bus.d_addr) : line_base(bus.i_addr);
          beat_nxt = '0;
          if (pick_d) begin
            state_nxt = bus.d_we ? D_WR : D_RD;
          end else begin
            state_nxt = I_RD;
          end
        end
      end

      default: begin
        if (last) begin
          state_nxt = IDLE;
          beat_nxt  = '0;
        end else if (beat_done) begin
          beat_nxt = beat + BEAT_W'(1);
        end
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Outputs: all forced to zero outside the relevant state so IDLE (and reset)
  // presents a quiet bus.
  // ---------------------------------------------------------------------------
  assign bus.mem_req   = busy;
  assign bus.mem_we    = (state == D_WR);
  assign bus.mem_addr  = busy ? (base | ADDR_W'({beat, 2'b00})) : '0;

  // Write data comes straight from the D-cache, which indexes its line with d_beat.
  assign bus.mem_wdata = (state == D_WR) ? bus.d_wdata : '0;
  assign bus.d_beat    = is_d ? beat : '0;

  // Read data is forwarded in the ack cycle; only the granted side sees rvalid.
  assign bus.i_rvalid  = is_rd_i & bus.mem_ack;
  assign bus.i_rdata   = (is_rd_i & bus.mem_ack) ? bus.mem_rdata : '0;
  assign bus.d_rvalid  = is_rd_d & bus.mem_ack;
  assign bus.d_rdata   = (is_rd_d & bus.mem_ack) ? bus.mem_rdata : '0;

  assign bus.i_done    = last & (state == I_RD);
  assign bus.d_done    = last & is_d;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a beat scoreboard and a simple memory/D-cache model.
// Latency: n/a. Backpressure: the bench drives mem_ack patterns to stall beats.
// Ports: none (top-level bench).
module tb_mem_port_arbiter;
  import cpu_mem_pkg::*;

  logic clk;
  logic resetn;

  mem_port_arbiter_if bus ();

  mem_port_arbiter dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory returns an address-derived word; the D-cache supplies a beat-derived word.
  function automatic logic [DATA_W-1:0] rd_model(input logic [ADDR_W-1:0] a);
    return {a[15:0], ~a[15:0]};
  endfunction

  function automatic logic [DATA_W-1:0] wr_model(input logic [BEAT_W-1:0] b);
    return 32'hBEEF_0000 | DATA_W'(b) * 32'h0000_0111;
  endfunction

  always_comb bus.mem_rdata = rd_model(bus.mem_addr);
  always_comb bus.d_wdata   = wr_model(bus.d_beat);

  typedef struct {
    logic              side_d;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [BEAT_W-1:0] beat;
    logic              last;
  } beat_t;

  beat_t sb[$];

  int   n_chk;
  int   n_fail;
  logic seen_i_done;
  logic seen_d_done;
  logic i_keep;
  logic d_keep;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic expect_burst(input logic side_d, input logic we, input logic [ADDR_W-1:0] addr);
    logic [ADDR_W-1:0] b;
    b = addr & LINE_MASK;
    for (int k = 0; k < LINE_WORDS; k++) begin
      sb.push_back('{side_d, we, b + ADDR_W'(4 * k), BEAT_W'(k), (k == LINE_WORDS - 1)});
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_mem_req"},   bus.mem_req,   0);
    chk({tag, "_mem_we"},    bus.mem_we,    0);
    chk({tag, "_mem_addr"},  bus.mem_addr,  0);
    chk({tag, "_mem_wdata"}, bus.mem_wdata, 0);
    chk({tag, "_i_rvalid"},  bus.i_rvalid,  0);
    chk({tag, "_i_rdata"},   bus.i_rdata,   0);
    chk({tag, "_i_done"},    bus.i_done,    0);
    chk({tag, "_d_rvalid"},  bus.d_rvalid,  0);
    chk({tag, "_d_rdata"},   bus.d_rdata,   0);
    chk({tag, "_d_done"},    bus.d_done,    0);
    chk({tag, "_d_beat"},    bus.d_beat,    0);
  endtask

  // Compare the current cycle against the scoreboard (called away from the clock edge).
  task automatic check_cycle();
    beat_t e;
    if (bus.mem_req === 1'b1 && bus.mem_ack === 1'b1) begin
      chk("beat_expected", sb.size() > 0, 1);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("mem_addr", bus.mem_addr, e.addr);
        chk("mem_we",   bus.mem_we,   e.we);
        chk("i_rvalid", bus.i_rvalid, !e.side_d);
        chk("d_rvalid", bus.d_rvalid, e.side_d && !e.we);
        if (!e.side_d) chk("i_rdata", bus.i_rdata, rd_model(e.addr));
        else if (!e.we) chk("d_rdata", bus.d_rdata, rd_model(e.addr));
        if (e.side_d) chk("d_beat", bus.d_beat, e.beat);
        if (e.we) chk("mem_wdata", bus.mem_wdata, wr_model(e.beat));
        chk("i_done", bus.i_done, !e.side_d && e.last);
        chk("d_done", bus.d_done, e.side_d && e.last);
        seen_i_done = seen_i_done | (bus.i_done === 1'b1);
        seen_d_done = seen_d_done | (bus.d_done === 1'b1);
      end
    end else begin
      chk("no_i_rvalid", bus.i_rvalid, 0);
      chk("no_d_rvalid", bus.d_rvalid, 0);
      chk("no_i_done",   bus.i_done,   0);
      chk("no_d_done",   bus.d_done,   0);
      if (bus.mem_req === 1'b1) begin
        chk("stall_expected", sb.size() > 0, 1);
        if (sb.size() > 0) begin
          chk("hold_addr", bus.mem_addr, sb[0].addr);
          chk("hold_we",   bus.mem_we,   sb[0].we);
          if (sb[0].side_d) chk("hold_d_beat", bus.d_beat, sb[0].beat);
        end
      end
    end
  endtask

  // mode: 0 = cycle must be idle, 1 = cycle must be a burst beat, 2 = either.
  task automatic step(input logic ack, input int mode);
    bus.mem_ack = ack;
    @(negedge clk);
    if (mode == 0) chk("idle_cycle", bus.mem_req, 0);
    if (mode == 1) chk("busy_cycle", bus.mem_req, 1);
    check_cycle();
    @(posedge clk);
    #1;
    // Requesters hold their request until done, then drop it.
    if (seen_i_done && !i_keep) bus.i_req = 1'b0;
    if (seen_d_done && !d_keep) bus.d_req = 1'b0;
    seen_i_done = 1'b0;
    seen_d_done = 1'b0;
  endtask

  task automatic burst_acked();
    for (int k = 0; k < LINE_WORDS; k++) step(1'b1, 1);
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    bus.mem_ack = 1'b0;
    repeat (2) @(posedge clk);
    #1;
  endtask

  int wb_pat[7] = '{1, 0, 0, 1, 1, 0, 1};

  initial begin
    n_chk       = 0;
    n_fail      = 0;
    seen_i_done = 1'b0;
    seen_d_done = 1'b0;
    i_keep      = 1'b0;
    d_keep      = 1'b0;
    bus.i_req   = 1'b0;
    bus.i_addr  = '0;
    bus.d_req   = 1'b0;
    bus.d_we    = 1'b0;
    bus.d_addr  = '0;
    bus.mem_ack = 1'b0;

    // Reset state
    do_reset();
    chk_zero("reset");
    resetn = 1'b1;

    // Single I read: 0x104C -> beats 0x1040..0x104C; ack in the idle cycle is ignored.
    bus.i_req  = 1'b1;
    bus.i_addr = 32'h0000_104C;
    expect_burst(1'b0, 1'b0, 32'h0000_104C);
    step(1'b1, 0);
    burst_acked();
    chk("i_burst_drained", sb.size(), 0);
    step(1'b0, 0);

    // Tie after an I grant: D (0x2000) first, one idle cycle, then I (0x6008).
    bus.i_req  = 1'b1;
    bus.i_addr = 32'h0000_6008;
    bus.d_req  = 1'b1;
    bus.d_we   = 1'b0;
    bus.d_addr = 32'h0000_2000;
    expect_burst(1'b1, 1'b0, 32'h0000_2000);
    expect_burst(1'b0, 1'b0, 32'h0000_6008);
    step(1'b0, 0);
    burst_acked();
    step(1'b1, 0);
    burst_acked();
    chk("tie_drained", sb.size(), 0);
    step(1'b0, 0);

    // D write-back at 0x3010 with stalls: d_done lands on the 7th cycle.
    bus.d_req  = 1'b1;
    bus.d_we   = 1'b1;
    bus.d_addr = 32'h0000_3010;
    expect_burst(1'b1, 1'b1, 32'h0000_3010);
    step(1'b0, 0);
    for (int k = 0; k < 7; k++) step(wb_pat[k][0], 1);
    chk("wb_drained", sb.size(), 0);
    step(1'b0, 0);

    // Both held for four bursts after reset: D, I, D, I.
    do_reset();
    chk_zero("reset2");
    resetn     = 1'b1;
    i_keep     = 1'b1;
    d_keep     = 1'b1;
    bus.i_req  = 1'b1;
    bus.i_addr = 32'h0000_8000;
    bus.d_req  = 1'b1;
    bus.d_we   = 1'b0;
    bus.d_addr = 32'h0000_7000;
    expect_burst(1'b1, 1'b0, 32'h0000_7000);
    expect_burst(1'b0, 1'b0, 32'h0000_8000);
    expect_burst(1'b1, 1'b0, 32'h0000_7000);
    expect_burst(1'b0, 1'b0, 32'h0000_8000);
    step(1'b0, 0);
    burst_acked();
    step(1'b0, 0);
    burst_acked();
    d_keep = 1'b0;
    step(1'b0, 0);
    burst_acked();
    i_keep = 1'b0;
    step(1'b0, 0);
    burst_acked();
    chk("alt_drained", sb.size(), 0);
    step(1'b0, 0);

    // Reset during beat 2 of an I burst, then a fresh D read starts at beat 0.
    bus.i_req  = 1'b1;
    bus.i_addr = 32'h0000_4000;
    expect_burst(1'b0, 1'b0, 32'h0000_4000);
    step(1'b0, 0);
    step(1'b1, 1);
    step(1'b1, 1);
    resetn = 1'b0;
    step(1'b0, 1);
    resetn    = 1'b1;
    bus.i_req = 1'b0;
    @(negedge clk);
    chk_zero("midreset");
    @(posedge clk);
    #1;
    sb.delete();
    bus.d_req  = 1'b1;
    bus.d_we   = 1'b0;
    bus.d_addr = 32'h0000_5004;
    expect_burst(1'b1, 1'b0, 32'h0000_5004);
    step(1'b0, 0);
    burst_acked();
    chk("post_reset_drained", sb.size(), 0);

    // mem_ack pulsed while idle: no response and no burst starts.
    for (int k = 0; k < 3; k++) step(1'b1, 0);
    chk("idle_ack_sb", sb.size(), 0);

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

endmodule
